// File: rtl/mem_arbiter_if.sv
// Core/memory bundle for mem_arbiter: instruction-fetch and load/store requester
// handshakes, the shared single-port memory port, and the busy flag.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_dout,
        output i_ready, i_rdata, d_ready, d_rdata,
               mem_addr, mem_din, mem_read, mem_write, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_dout,
        input  i_ready, i_rdata, d_ready, d_rdata,
               mem_addr, mem_din, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port word memory: data wins by default,
// a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
//
// state  | meaning
// IDLE   | waiting; requests sampled and one granted
// ACCESS | address/data held on memory, cnt counts down the latency
// DONE   | one-cycle ready pulse to the owner
module mem_arbiter #(
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          owner_data_q, owner_data_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic any_req;
    logic grant_data;

    assign any_req    = bus.i_req | bus.d_req;
    assign grant_data = bus.d_req & ~(bus.i_req & (streak_q == STREAK_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            streak_q     <= '0;
            owner_data_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            streak_q     <= streak_d;
            owner_data_q <= owner_data_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        streak_d     = streak_q;
        owner_data_d = owner_data_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d      = S_ACCESS;
                    cnt_d        = CNT_LOAD;
                    owner_data_d = grant_data;
                    write_d      = grant_data & bus.d_write;
                    if (grant_data) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        // streak only grows while a fetch is actually waiting
                        if (!bus.i_req)
                            streak_d = '0;
                        else if (streak_q != STREAK_MAX)
                            streak_d = streak_q + 1'b1;
                    end else begin
                        addr_d   = bus.i_addr;
                        streak_d = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    if (!write_q) begin
                        if (owner_data_q)
                            d_rdata_d = bus.mem_dout;
                        else
                            i_rdata_d = bus.mem_dout;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_read  = (state_q == S_ACCESS) & ~write_q;
        bus.mem_write = (state_q == S_ACCESS) & write_q & (cnt_q == '0);
        bus.i_ready   = (state_q == S_DONE) & ~owner_data_q;
        bus.d_ready   = (state_q == S_DONE) & owner_data_q;
        bus.busy      = (state_q != S_IDLE);
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = wdata_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios on LATENCY=2 and LATENCY=1 instances,
// plus a randomized run against a transaction-level timing/arbitration model.
module tb_mem_arbiter;
    localparam int L2 = 2;
    localparam int L1 = 1;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mem_arbiter_if bus2();
    mem_arbiter_if bus1();

    mem_arbiter #(.LATENCY(L2), .STARVE_LIMIT(SL)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    mem_arbiter #(.LATENCY(L1), .STARVE_LIMIT(SL)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    logic [31:0] mem2 [256] = '{default: '0};
    logic [31:0] mem1 [256] = '{default: '0};
    logic        pl2_we = 1'b0, pl1_we = 1'b0;
    logic [7:0]  pl2_idx = '0, pl1_idx = '0;
    logic [31:0] pl2_val = '0, pl1_val = '0;

    assign bus2.mem_dout = mem2[bus2.mem_addr[9:2]];
    assign bus1.mem_dout = mem1[bus1.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus2.mem_write) mem2[bus2.mem_addr[9:2]] <= bus2.mem_din;
        else if (pl2_we)    mem2[pl2_idx] <= pl2_val;
        if (bus1.mem_write) mem1[bus1.mem_addr[9:2]] <= bus1.mem_din;
        else if (pl1_we)    mem1[pl1_idx] <= pl1_val;
    end

    task automatic preload2(input logic [7:0] idx, input logic [31:0] val);
        pl2_idx = idx; pl2_val = val; pl2_we = 1'b1;
        @(posedge clk); #1 pl2_we = 1'b0;
    endtask

    task automatic preload1(input logic [7:0] idx, input logic [31:0] val);
        pl1_idx = idx; pl1_val = val; pl1_we = 1'b1;
        @(posedge clk); #1 pl1_we = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus2.i_req = 0; bus2.d_req = 0; bus1.i_req = 0; bus1.d_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_d2(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int rdc, output int wrc);
        @(negedge clk);
        bus2.d_req = 1; bus2.d_write = wr; bus2.d_addr = addr; bus2.d_wdata = wdata;
        lat = -1; rdc = 0; wrc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus2.mem_read)  rdc++;
            if (bus2.mem_write) wrc++;
            if (bus2.d_ready) begin lat = k; break; end
        end
        bus2.d_req = 0;
    endtask

    task automatic do_i2(input logic [31:0] addr, output int lat, output int rdc);
        @(negedge clk);
        bus2.i_req = 1; bus2.i_addr = addr;
        lat = -1; rdc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus2.mem_read) rdc++;
            if (bus2.i_ready) begin lat = k; break; end
        end
        bus2.i_req = 0;
    endtask

    task automatic test_reset();
        logic [132:0] obs2, obs1;
        rst_n = 1'b0;
        @(negedge clk);
        obs2 = {bus2.i_ready, bus2.d_ready, bus2.mem_read, bus2.mem_write, bus2.busy,
                bus2.i_rdata, bus2.d_rdata, bus2.mem_addr, bus2.mem_din};
        obs1 = {bus1.i_ready, bus1.d_ready, bus1.mem_read, bus1.mem_write, bus1.busy,
                bus1.i_rdata, bus1.d_rdata, bus1.mem_addr, bus1.mem_din};
        checks++;
        if (obs2 !== '0) begin errors++; $display("FAIL reset_outputs_L2 got %h want 0", obs2); end
        checks++;
        if (obs1 !== '0) begin errors++; $display("FAIL reset_outputs_L1 got %h want 0", obs1); end
    endtask

    task automatic test_single_fetch();
        int lat, rdc;
        reset_dut();
        preload2(8'h04, 32'h0000_0013);
        do_i2(32'h10, lat, rdc);
        checks++;
        if (lat !== L2 + 1) begin errors++; $display("FAIL fetch_latency got %0d want %0d", lat, L2 + 1); end
        checks++;
        if (bus2.i_rdata !== 32'h13) begin errors++; $display("FAIL fetch_rdata got %h want 00000013", bus2.i_rdata); end
        checks++;
        if (rdc !== L2) begin errors++; $display("FAIL fetch_mem_read_cycles got %0d want %0d", rdc, L2); end
        @(negedge clk);
        checks++;
        if ({bus2.i_ready, bus2.busy} !== 2'b00) begin
            errors++; $display("FAIL fetch_pulse_end got %b want 00", {bus2.i_ready, bus2.busy});
        end
    endtask

    task automatic test_store_load();
        int lat, rdc, wrc;
        reset_dut();
        preload2(8'h11, 32'h5A5A_5A5A);
        do_d2(1'b0, 32'h44, 32'h0, lat, rdc, wrc);
        checks++;
        if (bus2.d_rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL load44_rdata got %h want 5a5a5a5a", bus2.d_rdata); end
        do_d2(1'b1, 32'h40, 32'hDEAD_BEEF, lat, rdc, wrc);
        checks++;
        if (lat !== L2 + 1) begin errors++; $display("FAIL store_latency got %0d want %0d", lat, L2 + 1); end
        checks++;
        if (wrc !== 1 || rdc !== 0) begin errors++; $display("FAIL store_strobes got wr=%0d rd=%0d want wr=1 rd=0", wrc, rdc); end
        checks++;
        if (bus2.d_rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL store_keeps_rdata got %h want 5a5a5a5a", bus2.d_rdata); end
        checks++;
        if (mem2[8'h10] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem got %h want deadbeef", mem2[8'h10]); end
        do_d2(1'b0, 32'h40, 32'h0, lat, rdc, wrc);
        checks++;
        if (bus2.d_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load40_rdata got %h want deadbeef", bus2.d_rdata); end
    endtask

    task automatic test_contention();
        int got [10];
        int want [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int idx = 0;
        reset_dut();
        for (int i = 0; i < 10; i++) got[i] = 2;
        @(negedge clk);
        bus2.i_req = 1; bus2.i_addr = 32'h100;
        bus2.d_req = 1; bus2.d_write = 0; bus2.d_addr = 32'h200;
        for (int k = 0; k < 10 * (L2 + 2) + 10 && idx < 10; k++) begin
            @(negedge clk);
            if (bus2.d_ready) begin got[idx] = 1; idx++; end
            else if (bus2.i_ready) begin got[idx] = 0; idx++; end
        end
        bus2.i_req = 0; bus2.d_req = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++; $display("FAIL contention_grant%0d got %0d want %0d (1=data 0=instr 2=none)", i, got[i], want[i]);
            end
        end
        repeat (L2 + 3) @(negedge clk);
    endtask

    task automatic test_data_priority();
        int dk = -1, ik = -1;
        rst_n = 1'b0;
        @(negedge clk);
        bus2.i_req = 1; bus2.i_addr = 32'h10;
        bus2.d_req = 1; bus2.d_write = 0; bus2.d_addr = 32'h44;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus2.d_ready) begin dk = k; bus2.d_req = 0; end
            if (bus2.i_ready) begin ik = k; bus2.i_req = 0; break; end
        end
        bus2.i_req = 0; bus2.d_req = 0;
        checks++;
        if (dk !== L2 + 1) begin errors++; $display("FAIL priority_data_first got %0d want %0d", dk, L2 + 1); end
        checks++;
        if (ik - dk !== L2 + 2) begin errors++; $display("FAIL priority_fetch_gap got %0d want %0d", ik - dk, L2 + 2); end
    endtask

    task automatic test_reset_mid_store();
        int lat, rdc, wrc, bad = 0;
        logic [132:0] obs;
        reset_dut();
        preload2(8'h20, 32'h1111_1111);
        preload2(8'h21, 32'h0000_0077);
        do_d2(1'b0, 32'h84, 32'h0, lat, rdc, wrc);
        @(negedge clk);
        bus2.d_req = 1; bus2.d_write = 1; bus2.d_addr = 32'h80; bus2.d_wdata = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if (bus2.busy !== 1'b1) begin errors++; $display("FAIL midstore_busy got %b want 1", bus2.busy); end
        rst_n = 1'b0;
        #1;
        obs = {bus2.i_ready, bus2.d_ready, bus2.mem_read, bus2.mem_write, bus2.busy,
               bus2.i_rdata, bus2.d_rdata, bus2.mem_addr, bus2.mem_din};
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL midstore_reset_outputs got %h want 0", obs); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus2.d_ready || bus2.mem_write) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midstore_no_ready got %0d want 0", bad); end
        checks++;
        if (mem2[8'h20] !== 32'h1111_1111) begin errors++; $display("FAIL midstore_mem got %h want 11111111", mem2[8'h20]); end
        bus2.d_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency1();
        int t1 = -1, t2 = -1, rdc = 0;
        reset_dut();
        preload1(8'h00, 32'hA5A5_0001);
        preload1(8'h01, 32'h5A5A_0002);
        @(negedge clk);
        bus1.i_req = 1; bus1.i_addr = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus1.mem_read) rdc++;
            if (bus1.i_ready) begin
                if (t1 < 0) begin
                    t1 = k;
                    checks++;
                    if (bus1.i_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL lat1_word0 got %h want a5a50001", bus1.i_rdata); end
                    bus1.i_addr = 32'h4;
                end else begin
                    t2 = k;
                    checks++;
                    if (bus1.i_rdata !== 32'h5A5A_0002) begin errors++; $display("FAIL lat1_word1 got %h want 5a5a0002", bus1.i_rdata); end
                    break;
                end
            end
        end
        bus1.i_req = 0;
        checks++;
        if (t1 !== L1 + 1) begin errors++; $display("FAIL lat1_first got %0d want %0d", t1, L1 + 1); end
        checks++;
        if (t2 - t1 !== L1 + 2) begin errors++; $display("FAIL lat1_gap got %0d want %0d", t2 - t1, L1 + 2); end
        checks++;
        if (rdc !== 2 * L1) begin errors++; $display("FAIL lat1_mem_read got %0d want %0d", rdc, 2 * L1); end
    endtask

    // Transaction-level model: the memory is free every L2+2 cycles; grants follow
    // the priority/starvation rule; ready arrives L2 edges after the grant edge.
    task automatic test_random();
        int cyc = 0, free_at = 0, g_edge = -100, r_edge = -100, streak = 0, rdc = 0, wrc = 0;
        bit own_d = 0, own_wr = 0, gd, eir, edr, eb;
        bit ireq = 0, dreq = 0, dwr = 0;
        logic [31:0] ia = '0, da = '0, dw = '0, pend = '0, exp_i = '0, exp_d = '0;
        logic [31:0] ref_m [256];
        reset_dut();
        for (int i = 0; i < 256; i++) ref_m[i] = mem2[i];
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            cyc++;
            if (cyc >= free_at && (ireq || dreq)) begin
                gd = dreq && !(ireq && streak == SL);
                if (gd) streak = ireq ? ((streak == SL) ? SL : streak + 1) : 0;
                else    streak = 0;
                own_d = gd; own_wr = gd && dwr;
                if (gd) begin
                    if (dwr) ref_m[da[9:2]] = dw;
                    else     pend = ref_m[da[9:2]];
                end else begin
                    pend = ref_m[ia[9:2]];
                end
                g_edge = cyc; r_edge = cyc + L2; free_at = cyc + L2 + 2;
            end
            @(negedge clk);
            if (bus2.mem_read)  rdc++;
            if (bus2.mem_write) wrc++;
            eir = (cyc == r_edge) && !own_d;
            edr = (cyc == r_edge) && own_d;
            eb  = (cyc >= g_edge) && (cyc <= r_edge);
            if (eir) exp_i = pend;
            if (edr && !own_wr) exp_d = pend;
            checks++;
            if ({bus2.i_ready, bus2.d_ready, bus2.busy} !== {eir, edr, eb}) begin
                errors++; $display("FAIL rand_ctrl cyc %0d got %b want %b", cyc,
                                   {bus2.i_ready, bus2.d_ready, bus2.busy}, {eir, edr, eb});
            end
            checks++;
            if (bus2.i_rdata !== exp_i || bus2.d_rdata !== exp_d) begin
                errors++; $display("FAIL rand_rdata cyc %0d got i=%h d=%h want i=%h d=%h", cyc,
                                   bus2.i_rdata, bus2.d_rdata, exp_i, exp_d);
            end
            if (cyc == r_edge) begin
                checks++;
                if (rdc !== (own_wr ? 0 : L2) || wrc !== (own_wr ? 1 : 0)) begin
                    errors++; $display("FAIL rand_strobes cyc %0d got rd=%0d wr=%0d want rd=%0d wr=%0d", cyc,
                                       rdc, wrc, own_wr ? 0 : L2, own_wr ? 1 : 0);
                end
                rdc = 0; wrc = 0;
                if (own_d) dreq = 0; else ireq = 0;
            end
            if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1; ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dreq && $urandom_range(0, 3) != 0) begin
                dreq = 1; dwr = 1'($urandom_range(0, 1));
                da = {22'd0, 8'($urandom_range(0, 15)), 2'b00}; dw = $urandom;
            end
            bus2.i_req = ireq; bus2.i_addr = ia;
            bus2.d_req = dreq; bus2.d_write = dwr; bus2.d_addr = da; bus2.d_wdata = dw;
        end
        bus2.i_req = 0; bus2.d_req = 0;
        repeat (L2 + 4) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (mem2[i] !== ref_m[i]) begin
                errors++; $display("FAIL rand_mem word %0d got %h want %h", i, mem2[i], ref_m[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.i_req = 0; bus2.i_addr = '0; bus2.d_req = 0; bus2.d_write = 0; bus2.d_addr = '0; bus2.d_wdata = '0;
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_write = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_data_priority();
        test_reset_mid_store();
        test_latency1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port 32-bit word memory between the instruction-fetch path and the load/store path of the CPU. It sits between the core and the memory's address/din/mem_read/mem_write/dout port. It sequences each access over a fixed multi-cycle memory latency and returns read data through per-requester req/ready handshakes. Data accesses win by default; a starvation limit guarantees forward progress for instruction fetch.

## Interface
- LATENCY, default 2: memory access cycles per transaction, at least 1.
- STARVE_LIMIT, default 4: consecutive data grants allowed while an instruction request waits, at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  instruction read request; held with i_addr until i_ready.
- i_addr  in  32  instruction byte address.
- i_ready  out  1  one-cycle pulse: i_rdata is valid and the request is complete.
- i_rdata  out  32  last fetched instruction word.
- d_req  in  1  data request; held with d_write/d_addr/d_wdata until d_ready.
- d_write  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle pulse: access complete; d_rdata valid for loads.
- d_rdata  out  32  last loaded data word.
- mem_addr  out  32  byte address to memory, passed unchanged (memory divides by 4).
- mem_din  out  32  write data to memory.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable (memory writes on rising edge).
- mem_dout  in  32  memory read data, valid after LATENCY cycles of a stable address.
- busy  out  1  high in ACCESS and DONE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE, no request: stay.
- IDLE, any request: grant, latch addr/wdata/write/owner into mem_addr/mem_din/internal regs, load cnt = LATENCY-1, go to ACCESS.
- Grant rule: only one requester active -> grant it. Both active -> data, unless streak == STARVE_LIMIT, then instruction.
- streak counter:
  - +1 on a data grant while i_req = 1, saturating at STARVE_LIMIT.
  - Cleared on any instruction grant.
  - Cleared on a data grant while i_req = 0.
- ACCESS:
  - mem_read = 1 for a granted read.
  - mem_write = 1 only while cnt == 0 for a granted store, so exactly one write per store.
  - mem_addr and mem_din held stable; cnt decrements each cycle.
  - When cnt == 0: capture mem_dout into i_rdata or d_rdata (reads only), go to DONE.
- DONE: owner's ready = 1 for exactly one cycle, mem_read/mem_write = 0; next state IDLE unconditionally.
- Stores leave d_rdata unchanged. Each rdata register holds its value until that requester's next read completes.
- Request inputs are sampled only in IDLE. Changes during ACCESS/DONE are ignored for the in-flight transaction.

## Timing
- Reset values (applied immediately on assertion): state IDLE, cnt 0, streak 0, i_ready 0, d_ready 0, i_rdata 0, d_rdata 0, mem_addr 0, mem_din 0, mem_read 0, mem_write 0, busy 0.
- Latency: request sampled in IDLE at edge E -> ready high in cycle E+LATENCY+1.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Handshake: the requester drops or changes req at the edge where it sees ready high. The following IDLE cycle sees the new value.
- Reset asserted mid-ACCESS: transaction abandoned, no ready pulse, mem_write falls at once, no partial store.
- Reset release: first grant occurs at the first rising edge with reset = 1 and a request present.
- Simultaneous requests at reset release: data granted (streak = 0).
- LATENCY = 1: ACCESS lasts one cycle (cnt loads 0).

## Test plan
- Single fetch: LATENCY=2, mem word 0x00000013 at byte address 0x10, i_req with i_addr=0x10 -> i_ready pulses 3 cycles after grant edge, i_rdata=0x00000013, mem_read high exactly 2 cycles.
- Store then load: d_write=1, d_addr=0x40, d_wdata=0xDEADBEEF, then load 0x40 -> mem_write high exactly 1 cycle; load returns d_rdata=0xDEADBEEF; d_rdata unchanged after the store.
- Contention: i_req and d_req held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Data priority: i_req and d_req rise in the same cycle, streak 0 -> data served first; fetch completes 4 cycles after d_ready.
- Reset mid-store: reset low during the first ACCESS cycle of a store to 0x80 (old value 0x11111111) -> all outputs reset immediately, no d_ready, mem[0x80] still 0x11111111.
- LATENCY=1 back-to-back fetches at 0x0 and 0x4 -> i_ready pulses 3 cycles apart with correct words.
